// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between a fetch port and a data port.
// Latency: grant is combinational in the request cycle; rvalid/done and read data follow one cycle later.
// Backpressure: an ungranted requester keeps its request asserted; data wins unless the optional starvation guard forces fetch.
// Optional feature: define MEM_ARB_STARVE_EN to compile in the fetch starvation guard.
module mem_arbiter #(
    parameter int P_DATA_WIDTH   = 32,
    parameter int P_ADDR_WIDTH   = 11,
    parameter int P_STARVE_LIMIT = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    // fetch port
    input  logic                    i_i_req,
    input  logic [P_ADDR_WIDTH-1:0] i_i_addr,
    output logic                    o_i_gnt,
    output logic                    o_i_rvalid,
    output logic [P_DATA_WIDTH-1:0] o_i_rdata,
    // data port
    input  logic                    i_d_req,
    input  logic                    i_d_we,
    input  logic [P_ADDR_WIDTH-1:0] i_d_addr,
    input  logic [P_DATA_WIDTH-1:0] i_d_wdata,
    output logic                    o_d_gnt,
    output logic                    o_d_done,
    output logic [P_DATA_WIDTH-1:0] o_d_rdata,
    // shared RAM
    output logic                    o_mem_en,
    output logic                    o_mem_we,
    output logic [P_ADDR_WIDTH-1:0] o_mem_addr,
    output logic [P_DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [P_DATA_WIDTH-1:0] i_mem_rdata
);

    // The starvation counter is 4 bits wide, so the limit must fit in it.
    if (P_STARVE_LIMIT < 1 || P_STARVE_LIMIT > 15) begin : g_bad_limit
        $error("mem_arbiter: P_STARVE_LIMIT must be in 1..15");
    end

    logic i_gnt;
    logic d_gnt;
    logic starve_hit;

    // Response tracking: which port was granted last cycle and whether it was a read.
    logic                    i_rvalid_q, i_rvalid_d;
    logic                    d_done_q,   d_done_d;
    logic                    d_rd_q,     d_rd_d;
    logic [P_DATA_WIDTH-1:0] i_rdata_q,  i_rdata_d;
    logic [P_DATA_WIDTH-1:0] d_rdata_q,  d_rdata_d;
    logic                    i_resp_vld;
    logic                    d_resp_vld;

`ifdef MEM_ARB_STARVE_EN
    localparam logic [3:0] STARVE_LIMIT = 4'(P_STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;

    // Count consecutive cycles the fetch port is asking but not being served.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (i_i_req && !i_gnt) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else begin
            starve_cnt_d = 4'd0;
        end
    end

    // Starvation counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign starve_hit = (starve_cnt_q == STARVE_LIMIT);
`else
    // Pure fixed priority: fetch never overrides data.
    assign starve_hit = 1'b0;
`endif

    // Grant selection: forced fetch, then data, then fetch; nothing during reset.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!i_rst) begin
            if (i_i_req && starve_hit) begin
                i_gnt = 1'b1;
            end else if (i_d_req) begin
                d_gnt = 1'b1;
            end else if (i_i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    assign o_i_gnt = i_gnt;
    assign o_d_gnt = d_gnt;

    // RAM port steering for the winning requester.
    always_comb begin
        o_mem_en    = i_gnt | d_gnt;
        o_mem_we    = d_gnt & i_d_we;
        o_mem_addr  = d_gnt ? i_d_addr : i_i_addr;
        o_mem_wdata = i_d_wdata;
    end

    // A reset in the response cycle swallows the pulse and its data.
    assign i_resp_vld = i_rvalid_q & ~i_rst;
    assign d_resp_vld = d_done_q & ~i_rst;

    // Next-state for response flags and held read data.
    always_comb begin
        i_rvalid_d = i_gnt;
        d_done_d   = d_gnt;
        d_rd_d     = d_gnt & ~i_d_we;
        i_rdata_d  = i_resp_vld ? i_mem_rdata : i_rdata_q;
        d_rdata_d  = (d_resp_vld && d_rd_q) ? i_mem_rdata : d_rdata_q;
    end

    // Response state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            i_rvalid_q <= 1'b0;
            d_done_q   <= 1'b0;
            d_rd_q     <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            i_rvalid_q <= i_rvalid_d;
            d_done_q   <= d_done_d;
            d_rd_q     <= d_rd_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // RAM data is live during the response cycle, so it bypasses the holding register.
    assign o_i_rvalid = i_resp_vld;
    assign o_d_done   = d_resp_vld;
    assign o_i_rdata  = i_rdata_d;
    assign o_d_rdata  = d_rdata_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM environment, cycle-level reference model, directed stimulus.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
// Starvation expectations follow whether MEM_ARB_STARVE_EN is defined.
module tb_mem_arbiter;
    localparam int DW    = 32;
    localparam int AW    = 11;
    localparam int LIMIT = 4;
    localparam int DEPTH = 2048;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          i_gnt, i_rvalid, d_gnt, d_done;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW), .P_STARVE_LIMIT(LIMIT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_i_req(i_req), .i_i_addr(i_addr), .o_i_gnt(i_gnt),
        .o_i_rvalid(i_rvalid), .o_i_rdata(i_rdata),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .o_d_gnt(d_gnt), .o_d_done(d_done), .o_d_rdata(d_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    // Environment RAM (what the DUT actually drives) and the model's shadow copy.
    logic [DW-1:0] ram    [DEPTH];
    logic [DW-1:0] shadow [DEPTH];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: what happened at the previous edge.
    logic          m_prev_i = 1'b0, m_prev_d = 1'b0, m_prev_drd = 1'b0;
    logic [DW-1:0] m_prev_ival = '0, m_prev_dval = '0;
    logic [DW-1:0] m_ihold = '0, m_dhold = '0;
    int            m_deny = 0;

    always @(negedge clk) begin
        logic          forced, eg_i, eg_d, e_rv, e_dn;
        logic [DW-1:0] e_ir, e_dr;
        forced = 1'b0;
`ifdef MEM_ARB_STARVE_EN
        forced = i_req && (m_deny >= LIMIT);
`endif
        eg_i = 1'b0;
        eg_d = 1'b0;
        if (!rst) begin
            if (forced)     eg_i = 1'b1;
            else if (d_req) eg_d = 1'b1;
            else if (i_req) eg_i = 1'b1;
        end
        chk("m_i_gnt", i_gnt, eg_i);
        chk("m_d_gnt", d_gnt, eg_d);
        chk("m_mem_en", mem_en, eg_i | eg_d);
        chk("m_mem_we", mem_we, eg_d & d_we);
        if (eg_i) chk("m_mem_addr_i", mem_addr, i_addr);
        if (eg_d) chk("m_mem_addr_d", mem_addr, d_addr);
        if (eg_d && d_we) chk("m_mem_wdata", mem_wdata, d_wdata);

        e_rv = m_prev_i && !rst;
        e_ir = e_rv ? m_prev_ival : m_ihold;
        e_dn = m_prev_d && !rst;
        e_dr = (e_dn && m_prev_drd) ? m_prev_dval : m_dhold;
        chk("m_i_rvalid", i_rvalid, e_rv);
        chk("m_i_rdata", i_rdata, e_ir);
        chk("m_d_done", d_done, e_dn);
        chk("m_d_rdata", d_rdata, e_dr);

        // Advance the model across the coming rising edge.
        if (rst) begin
            m_ihold = '0;
            m_dhold = '0;
        end else begin
            m_ihold = e_ir;
            m_dhold = e_dr;
        end
        m_prev_i    = eg_i;
        m_prev_ival = shadow[i_addr];
        m_prev_d    = eg_d;
        m_prev_drd  = eg_d && !d_we;
        m_prev_dval = shadow[d_addr];
        if (eg_d && d_we) shadow[d_addr] = d_wdata;
        if (rst || !i_req || eg_i) m_deny = 0;
        else                       m_deny = m_deny + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    endtask

    initial begin
        int n_fetch, first_fetch;
        for (int a = 0; a < DEPTH; a++) begin
            ram[a]    = 32'(a) * 32'h9E37_79B1;
            shadow[a] = 32'(a) * 32'h9E37_79B1;
        end
        ram[5]    = 32'hDEAD_BEEF;
        shadow[5] = 32'hDEAD_BEEF;
        mem_rdata = '0;
        rst = 1'b1;
        idle();
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_i_rvalid", i_rvalid, 0);
        chk("rst_d_done", d_done, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);

        // Fetch-only read of address 5.
        tick(); i_req = 1'b1; i_addr = 11'd5;
        @(negedge clk); chk("fetch_gnt", i_gnt, 1);
        tick(); idle();
        @(negedge clk);
        chk("fetch_rvalid", i_rvalid, 1);
        chk("fetch_rdata", i_rdata, 32'hDEAD_BEEF);

        // Collision: data write wins, fetch follows.
        tick(); i_req = 1'b1; i_addr = 11'd9;
        d_req = 1'b1; d_we = 1'b1; d_addr = 11'd3; d_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("coll_d_gnt", d_gnt, 1);
        chk("coll_i_gnt", i_gnt, 0);
        chk("coll_mem_we", mem_we, 1);
        tick(); d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("coll_d_done", d_done, 1);
        chk("coll_i_gnt2", i_gnt, 1);
        tick(); idle();
        @(negedge clk); chk("coll_rvalid", i_rvalid, 1);

        // Write then read back address 7.
        tick(); d_req = 1'b1; d_we = 1'b1; d_addr = 11'd7; d_wdata = 32'hA5A5_A5A5;
        tick(); d_we = 1'b0;
        tick(); idle();
        @(negedge clk);
        chk("wr_rd_done", d_done, 1);
        chk("wr_rd_data", d_rdata, 32'hA5A5_A5A5);

        // Alternating single-port requests every cycle.
        for (int k = 0; k < 8; k++) begin
            tick();
            d_req = (k % 2 == 0); d_we = (k == 2); d_addr = 11'(100 + k);
            d_wdata = 32'h0F0F_0000 + 32'(k);
            i_req = (k % 2 == 1); i_addr = 11'(100 + k - 2);
        end
        tick(); idle();

        // Fetch request dropped before being granted.
        tick(); i_req = 1'b1; i_addr = 11'd40; d_req = 1'b1; d_addr = 11'd41;
        tick(); idle();
        tick();
        @(negedge clk); chk("drop_no_rvalid", i_rvalid, 0);

        // Both ports held high continuously.
        tick(); i_req = 1'b1; i_addr = 11'd50; d_req = 1'b1; d_we = 1'b0; d_addr = 11'd60;
        n_fetch = 0;
        first_fetch = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (i_gnt) begin
                n_fetch++;
                if (first_fetch == 0) first_fetch = c;
            end
            tick();
        end
`ifdef MEM_ARB_STARVE_EN
        chk("starve_first", 32'(first_fetch), 5);
        chk("starve_count", 32'(n_fetch), 4);
`else
        chk("nostarve_count", 32'(n_fetch), 0);
`endif
        d_req = 1'b0;
        @(negedge clk); chk("starve_release", i_gnt, 1);
        tick(); idle();

        // Reset right after a fetch grant.
        tick(); i_req = 1'b1; i_addr = 11'd20;
        @(negedge clk); chk("rstmid_gnt", i_gnt, 1);
        tick(); idle(); rst = 1'b1;
        @(negedge clk); chk("rstmid_rvalid", i_rvalid, 0);
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("rstmid_rvalid2", i_rvalid, 0);
        chk("rstmid_rdata", i_rdata, 0);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
